// File: rtl/ic_rgbtoycbcr_mux_ctrl_pkg.sv
// Shared constants for the RGB-to-YCbCr output mux sequencer:
// one-hot mux selects, component ids and FSM encoding.
package ic_rgbtoycbcr_pkg;

  localparam int ROWS_DEF = 8;

  localparam logic [2:0] SEL_NONE = 3'b000;
  localparam logic [2:0] SEL_Y    = 3'b001;
  localparam logic [2:0] SEL_CB   = 3'b010;
  localparam logic [2:0] SEL_CR   = 3'b100;

  localparam logic [1:0] COMP_Y    = 2'd0;
  localparam logic [1:0] COMP_CB   = 2'd1;
  localparam logic [1:0] COMP_CR   = 2'd2;
  localparam logic [1:0] COMP_IDLE = 2'd3;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_Y    = 2'd1;
  localparam logic [1:0] ST_CB   = 2'd2;
  localparam logic [1:0] ST_CR   = 2'd3;

  function automatic logic [2:0] state_sel(input logic [1:0] s);
    case (s)
      ST_Y:    return SEL_Y;
      ST_CB:   return SEL_CB;
      ST_CR:   return SEL_CR;
      default: return SEL_NONE;
    endcase
  endfunction

  function automatic logic [1:0] state_comp(input logic [1:0] s);
    case (s)
      ST_Y:    return COMP_Y;
      ST_CB:   return COMP_CB;
      ST_CR:   return COMP_CR;
      default: return COMP_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/ic_rgbtoycbcr_mux_ctrl.sv
// Sequences Y, Cb, Cr row buffers into component-ordered blocks for the DCT,
// driving the external one-hot 3:1 mux select and per-channel pop acks.
module ic_rgbtoycbcr_mux_ctrl
  import ic_rgbtoycbcr_pkg::*;
#(
  parameter int ROWS  = ROWS_DEF,
  parameter int CNT_W = 3,
  parameter int BLK_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             y_valid,
  input  logic             cb_valid,
  input  logic             cr_valid,
  input  logic             out_ready,
  output logic [2:0]       select,
  output logic             y_ack,
  output logic             cb_ack,
  output logic             cr_ack,
  output logic             out_valid,
  output logic [1:0]       comp_id,
  output logic [CNT_W-1:0] row_idx,
  output logic             block_done,
  output logic [BLK_W-1:0] blk_count
);

  localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(ROWS - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] row_q, row_d;
  logic [BLK_W-1:0] blk_q, blk_d;
  logic             done_q, done_d;
  logic [2:0]       sel_q;
  logic [1:0]       comp_q;
  logic             xfer;

  always_comb begin
    out_valid = 1'b0;
    case (state_q)
      ST_Y:    out_valid = y_valid;
      ST_CB:   out_valid = cb_valid;
      ST_CR:   out_valid = cr_valid;
      default: out_valid = 1'b0;
    endcase
    xfer   = out_valid & out_ready;
    y_ack  = xfer & (state_q == ST_Y);
    cb_ack = xfer & (state_q == ST_CB);
    cr_ack = xfer & (state_q == ST_CR);
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    blk_d   = blk_q;
    done_d  = 1'b0;
    if (state_q == ST_IDLE) begin
      if (enable) begin
        state_d = ST_Y;
        row_d   = '0;
      end
    end else if (xfer) begin
      if (row_q == LAST_ROW) begin
        row_d = '0;
        case (state_q)
          ST_Y:  state_d = ST_CB;
          ST_CB: state_d = ST_CR;
          default: begin
            // Back-to-back blocks start without a bubble when still enabled.
            done_d  = 1'b1;
            blk_d   = blk_q + 1'b1;
            state_d = enable ? ST_Y : ST_IDLE;
          end
        endcase
      end else begin
        row_d = row_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      row_q   <= '0;
      blk_q   <= '0;
      done_q  <= 1'b0;
      sel_q   <= SEL_NONE;
      comp_q  <= COMP_IDLE;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      blk_q   <= blk_d;
      done_q  <= done_d;
      sel_q   <= state_sel(state_d);
      comp_q  <= state_comp(state_d);
    end
  end

  assign select     = sel_q;
  assign comp_id    = comp_q;
  assign row_idx    = row_q;
  assign block_done = done_q;
  assign blk_count  = blk_q;

endmodule

// File: tb/tb_ic_rgbtoycbcr_mux_ctrl.sv
// Randomized scoreboard bench: a phase/row/block reference model predicts each
// cycle's outputs; a separate monitor pops and compares against the DUT.
module tb_ic_rgbtoycbcr_mux_ctrl;

  localparam int ROWS  = 8;
  localparam int CNT_W = 3;
  localparam int BLK_W = 2;

  logic             clk = 1'b0;
  logic             reset, enable, y_valid, cb_valid, cr_valid, out_ready;
  logic [2:0]       select;
  logic             y_ack, cb_ack, cr_ack, out_valid, block_done;
  logic [1:0]       comp_id;
  logic [CNT_W-1:0] row_idx;
  logic [BLK_W-1:0] blk_count;

  always #5 clk = ~clk;

  ic_rgbtoycbcr_mux_ctrl #(.ROWS(ROWS), .CNT_W(CNT_W), .BLK_W(BLK_W)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .y_valid(y_valid), .cb_valid(cb_valid), .cr_valid(cr_valid),
    .out_ready(out_ready), .select(select),
    .y_ack(y_ack), .cb_ack(cb_ack), .cr_ack(cr_ack),
    .out_valid(out_valid), .comp_id(comp_id), .row_idx(row_idx),
    .block_done(block_done), .blk_count(blk_count)
  );

  typedef struct {
    int cyc;
    int sel, comp, row, ov, ack, done, blk;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int n_done_seen = 0;

  // Reference model: phase -1 = idle, 0/1/2 = Y/Cb/Cr.
  int m_phase = -1;
  int m_row   = 0;
  int m_blk   = 0;
  int m_done  = 0;

  task automatic chk(input string name, input int cyc, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  initial begin : driver
    int v[3];
    int rdy, en, rst;
    exp_t e;
    reset = 1'b1; enable = 1'b0; out_ready = 1'b0;
    y_valid = 1'b0; cb_valid = 1'b0; cr_valid = 1'b0;
    repeat (3) @(posedge clk);
    for (int c = 0; c < 2400; c++) begin
      @(negedge clk);
      rst = 0;
      if (c < 4) begin
        v = '{1, 1, 1}; rdy = 1; en = 0;
      end else if (c < 100) begin
        v = '{1, 1, 1}; rdy = 1; en = 1;
      end else if (c < 250) begin
        v = '{1, 1, 1}; rdy = c % 2; en = 1;
      end else if (c < 1000) begin
        for (int k = 0; k < 3; k++) v[k] = ($urandom_range(0, 9) < 8);
        rdy = ($urandom_range(0, 9) < 7);
        en  = ($urandom_range(0, 9) < 9);
      end else if (c < 1800) begin
        for (int k = 0; k < 3; k++) v[k] = ($urandom_range(0, 9) < 6);
        rdy = ($urandom_range(0, 1));
        en  = ($urandom_range(0, 1));
        rst = ($urandom_range(0, 119) == 0);
      end else begin
        v = '{1, 1, 1}; rdy = 1; en = (c < 2300);
      end
      if (c == 0) rst = 1;
      reset = rst[0]; enable = en[0]; out_ready = rdy[0];
      y_valid = v[0][0]; cb_valid = v[1][0]; cr_valid = v[2][0];

      e.cyc  = c;
      e.sel  = (m_phase < 0) ? 0 : (1 << m_phase);
      e.comp = (m_phase < 0) ? 3 : m_phase;
      e.row  = m_row;
      e.ov   = (m_phase < 0) ? 0 : v[m_phase];
      e.ack  = (e.ov && rdy) ? e.sel : 0;
      e.done = m_done;
      e.blk  = m_blk % (1 << BLK_W);
      q.push_back(e);

      if (rst) begin
        m_phase = -1; m_row = 0; m_blk = 0; m_done = 0;
      end else if (m_phase < 0) begin
        m_done = 0;
        if (en) begin m_phase = 0; m_row = 0; end
      end else if (e.ack != 0) begin
        m_done = 0;
        m_row++;
        if (m_row == ROWS) begin
          m_row = 0;
          m_phase++;
          if (m_phase == 3) begin
            m_done = 1;
            m_blk++;
            m_phase = en ? 0 : -1;
          end
        end
      end else begin
        m_done = 0;
      end
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL queue_drain: %0d entries left, expected 0", q.size());
    end
    n_cmp++;
    if (n_done_seen < 20) begin
      n_bad++;
      $display("FAIL block_count_coverage: saw %0d block_done pulses, expected at least 20", n_done_seen);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("select",     e.cyc, int'(select),     e.sel);
        chk("comp_id",    e.cyc, int'(comp_id),    e.comp);
        chk("row_idx",    e.cyc, int'(row_idx),    e.row);
        chk("out_valid",  e.cyc, int'(out_valid),  e.ov);
        chk("acks",       e.cyc, int'({cr_ack, cb_ack, y_ack}), e.ack);
        chk("block_done", e.cyc, int'(block_done), e.done);
        chk("blk_count",  e.cyc, int'(blk_count),  e.blk);
        if (block_done === 1'b1) n_done_seen++;
      end
    end
  end

endmodule
